// File: rtl/prng_stream.sv
// Streaming pseudo-random generator (LCG or Galois LFSR) with bounded output by
// mask-and-reject, a ready/valid output slot, and a saturating rejection counter.
module prng_stream #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] SEED       = DATA_WIDTH'(123456),
    parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = DATA_WIDTH'(32'h80200003),
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  seed_load,
    input  logic [DATA_WIDTH-1:0] seed_in,
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] bound,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  rej_count
);

    localparam logic [DATA_WIDTH-1:0] LCG_MUL = DATA_WIDTH'(64'd1103515245);
    localparam logic [DATA_WIDTH-1:0] LCG_INC = DATA_WIDTH'(64'd12345);

    logic [DATA_WIDTH-1:0] state;
    logic [DATA_WIDTH-1:0] lfsr_src;
    logic [DATA_WIDTH-1:0] lfsr_next;
    logic [DATA_WIDTH-1:0] lcg_next;
    logic [DATA_WIDTH-1:0] next_state;
    logic [DATA_WIDTH-1:0] limit;
    logic [DATA_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] candidate;
    logic                  accept;
    logic                  advance;

    // The slot is free when empty or being drained this cycle; seed_load wins.
    assign advance = !seed_load && (!out_valid || out_ready);

    // NOTE: every always_comb output gets a value before any branch or loop, so no latch can be inferred.
    always_comb begin
        lfsr_src  = state;
        lfsr_next = '0;
        lcg_next  = '0;
        limit     = '0;
        mask      = '0;

        // An all-zero state would lock the LFSR; treat it as 1 and step from there.
        if (state == '0) begin
            lfsr_src = DATA_WIDTH'(1);
        end
        lfsr_next = lfsr_src[0] ? ((lfsr_src >> 1) ^ LFSR_TAPS) : (lfsr_src >> 1);
        lcg_next  = state * LCG_MUL + LCG_INC;

        next_state = mode ? lfsr_next : lcg_next;

        // Smear the MSB of (bound-1) downward so the mask covers exactly the needed bits.
        limit = bound - DATA_WIDTH'(1);
        for (int i = 0; i < DATA_WIDTH; i++) begin
            mask[i] = |(limit >> i);
        end
        if (bound == '0) begin
            mask = '1;
        end

        candidate = next_state & mask;
        accept    = (bound == '0) || (candidate < bound);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEED;
            out_valid <= 1'b0;
            out_data  <= '0;
            rej_count <= '0;
        end else if (seed_load) begin
            state     <= seed_in;
            out_valid <= 1'b0;
            rej_count <= '0;
        end else if (advance) begin
            state <= next_state;
            if (accept) begin
                out_data  <= candidate;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
                if (rej_count != '1) begin
                    rej_count <= rej_count + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_prng_stream.sv
// Directed bench for prng_stream: expected stream values go into a scoreboard
// queue, and a negedge monitor pops and compares every accepted transfer.
module tb_prng_stream;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          seed_load;
    logic [DW-1:0] seed_in;
    logic          mode;
    logic [DW-1:0] bound;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] rej_count;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] sb[$];

    // LFSR sequence from state 1 with taps 0x80200003, worked out by hand.
    localparam logic [DW-1:0] L1 = 32'h80200003;
    localparam logic [DW-1:0] L2 = 32'hC0300002;
    localparam logic [DW-1:0] L3 = 32'h60180001;
    localparam logic [DW-1:0] L4 = 32'hB02C0003;
    localparam logic [DW-1:0] LCG_FIRST = 32'd3510437241;

    prng_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .mode      (mode),
        .bound     (bound),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rej_count (rej_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Transfers happen at the posedge following a negedge where valid && ready.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got 0x%0h, expected no transfer (t=%0t)", out_data, $time);
            end else begin
                check("stream_data", out_data, sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_seed(input logic [DW-1:0] s, input logic m, input logic [DW-1:0] b);
        out_ready = 1'b0;
        seed_load = 1'b1;
        seed_in   = s;
        mode      = m;
        bound     = b;
        step();
        check("seed_clears_valid", out_valid, 1'b0);
        check("seed_clears_rej", rej_count, '0);
        seed_load = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        seed_load = 1'b0;
        seed_in   = '0;
        mode      = 1'b0;
        bound     = '0;
        out_ready = 1'b0;
        #3;
        check("reset_valid", out_valid, 1'b0);
        check("reset_data", out_data, '0);
        check("reset_rej", rej_count, '0);
        #4 rst_n = 1'b1;

        // LCG first value one cycle after release.
        step();
        check("lcg_first_valid", out_valid, 1'b1);
        check("lcg_first_data", out_data, LCG_FIRST);
        sb.push_back(LCG_FIRST);
        out_ready = 1'b1;
        step();

        // LFSR from seed 1, unbounded, then a 5-cycle stall holding L3.
        do_seed(32'd1, 1'b1, '0);
        out_ready = 1'b1;
        sb.push_back(L1);
        sb.push_back(L2);
        sb.push_back(L3);
        step();
        step();
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid", out_valid, 1'b1);
            check("stall_data", out_data, L3);
        end
        out_ready = 1'b1;
        sb.push_back(L4);
        step();
        step();

        // bound=3 masks to 2 bits: L1&3=3 rejected, then 2, 1, then L4&3=3 rejected.
        do_seed(32'd1, 1'b1, 32'd3);
        out_ready = 1'b1;
        sb.push_back(32'd2);
        sb.push_back(32'd1);
        step();
        check("reject_valid", out_valid, 1'b0);
        check("reject_count1", rej_count, 16'd1);
        step();
        check("after_reject_valid", out_valid, 1'b1);
        check("after_reject_data", out_data, 32'd2);
        step();
        step();
        check("reject2_valid", out_valid, 1'b0);
        check("reject_count2", rej_count, 16'd2);
        out_ready = 1'b0;
        step();
        check("held_before_reset", out_valid, 1'b1);

        // Asynchronous reset mid-stream, away from any clock edge.
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_valid", out_valid, 1'b0);
        check("async_reset_rej", rej_count, '0);
        check("async_reset_data", out_data, '0);
        mode  = 1'b0;
        bound = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("restart_valid", out_valid, 1'b1);
        sb.push_back(LCG_FIRST);
        out_ready = 1'b1;
        step();

        // Zero seed in LFSR mode escapes lock-up by stepping from 1.
        do_seed('0, 1'b1, '0);
        out_ready = 1'b1;
        sb.push_back(L1);
        step();
        check("zero_seed_data", out_data, L1);
        step();

        // bound=1 gives mask 0: every candidate is 0 and accepted.
        do_seed(32'd1, 1'b1, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) sb.push_back('0);
        step();
        step();
        step();
        step();
        out_ready = 1'b0;
        check("bound1_no_reject", rej_count, '0);
        step();

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
